// File: rtl/egress_frame_reader_if.sv
// Bundles the descriptor, RAM read, egress stream, credit-return and error signals of
// egress_frame_reader. The slave modport is the reader's view; master is its environment.
interface egress_frame_reader_if #(
  parameter int unsigned ADDR_BITS = 18,
  parameter int unsigned LEN_BITS  = 14,
  parameter int unsigned PORT_BITS = 4
);
  logic                  desc_valid;
  logic                  desc_ready;
  logic [ADDR_BITS-1:0]  desc_addr;
  logic [LEN_BITS-1:0]   desc_len;
  logic [PORT_BITS-1:0]  desc_port;

  logic                  ram_rd_en;
  logic [ADDR_BITS-1:0]  ram_rd_addr;
  logic                  ram_rd_valid;
  logic [143:0]          ram_rd_data;

  logic                  eg_valid;
  logic                  eg_ready;
  logic [127:0]          eg_data;
  logic [4:0]            eg_bytes;
  logic                  eg_start;
  logic                  eg_last;
  logic [PORT_BITS-1:0]  eg_port;

  logic                  free_valid;
  logic [LEN_BITS-4:0]   free_words;
  logic                  err_zero_len;
  logic                  err_unexpected_rd;

  modport slave (
    input  desc_valid, desc_addr, desc_len, desc_port, ram_rd_valid, ram_rd_data, eg_ready,
    output desc_ready, ram_rd_en, ram_rd_addr, eg_valid, eg_data, eg_bytes, eg_start, eg_last,
           eg_port, free_valid, free_words, err_zero_len, err_unexpected_rd
  );

  modport master (
    output desc_valid, desc_addr, desc_len, desc_port, ram_rd_valid, ram_rd_data, eg_ready,
    input  desc_ready, ram_rd_en, ram_rd_addr, eg_valid, eg_data, eg_bytes, eg_start, eg_last,
           eg_port, free_valid, free_words, err_zero_len, err_unexpected_rd
  );
endinterface

// File: rtl/egress_frame_reader.sv
// Reads one buffered frame at a time out of packet RAM, reorders nothing (returns are in issue
// order) and reframes the words into an egress beat stream, returning ring credit per frame.
module egress_frame_reader #(
  parameter int unsigned ADDR_BITS  = 18,
  parameter int unsigned LEN_BITS   = 14,
  parameter int unsigned PORT_BITS  = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 i_clk_ram_ctl,
  input  logic                 i_rst,
  egress_frame_reader_if.slave io_bus
);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned WordsW = LEN_BITS - 3;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  typedef struct packed {
    logic                 start;
    logic                 last;
    logic [4:0]           bytes;
    logic [PORT_BITS-1:0] port;
    logic [WordsW-1:0]    words;
  } tag_t;

  typedef struct packed {
    logic [127:0]         data;
    logic                 start;
    logic                 last;
    logic [4:0]           bytes;
    logic [PORT_BITS-1:0] port;
  } beat_t;

  state_e               r_state, w_state_next;
  logic                 w_desc_ready, w_desc_fire, w_rd_en, w_credit;
  logic [LEN_BITS:0]    w_len_round;
  logic [WordsW-1:0]    w_desc_words;
  logic [4:0]           w_desc_last_bytes;
  logic [CntW:0]        w_inflight;

  logic [ADDR_BITS-1:0] r_addr;
  logic [PORT_BITS-1:0] r_port;
  logic [WordsW-1:0]    r_rem, r_words;
  logic [4:0]           r_last_bytes;
  logic                 r_first;

  tag_t                 r_tag_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_tag_wr, r_tag_rd;
  logic [CntW-1:0]      r_tag_count;
  tag_t                 w_tag_new, w_tag_head;
  logic                 w_tag_pop;

  beat_t                r_data_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_data_wr, r_data_rd;
  logic [CntW-1:0]      r_data_count;
  beat_t                w_data_new, w_data_head;
  logic                 w_data_pop, w_eg_valid;

  logic                 r_free_valid;
  logic [WordsW-1:0]    r_free_words;
  logic                 r_err_zero, r_err_unexp;
  logic                 w_unused_hi;

  assign w_len_round       = {1'b0, io_bus.desc_len} + (LEN_BITS + 1)'(15);
  assign w_desc_words      = w_len_round[LEN_BITS:4];
  assign w_desc_last_bytes = (io_bus.desc_len[3:0] == 4'd0) ? 5'd16 : {1'b0, io_bus.desc_len[3:0]};
  assign w_desc_fire       = w_desc_ready & io_bus.desc_valid;

  // Registered counts only: a same-cycle return or retire is seen one cycle late, so the
  // credit can under-issue but never over-issue.
  assign w_inflight = {1'b0, r_tag_count} + {1'b0, r_data_count};
  assign w_credit   = w_inflight < (CntW + 1)'(FIFO_DEPTH);

  always_ff @(posedge i_clk_ram_ctl) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_desc_ready = 1'b0;
    w_rd_en      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_desc_ready = !i_rst;
        if (w_desc_fire && (io_bus.desc_len != '0)) w_state_next = StRead;
      end
      StRead: begin
        w_rd_en = w_credit && !i_rst;
        if (w_rd_en && (r_rem == WordsW'(1))) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_ram_ctl) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_port       <= '0;
      r_rem        <= '0;
      r_words      <= '0;
      r_last_bytes <= '0;
      r_first      <= 1'b0;
    end else if (w_desc_fire && (io_bus.desc_len != '0)) begin
      r_addr       <= io_bus.desc_addr;
      r_port       <= io_bus.desc_port;
      r_rem        <= w_desc_words;
      r_words      <= w_desc_words;
      r_last_bytes <= w_desc_last_bytes;
      r_first      <= 1'b1;
    end else if (w_rd_en) begin
      r_addr  <= r_addr + ADDR_BITS'(1);
      r_rem   <= r_rem - WordsW'(1);
      r_first <= 1'b0;
    end
  end

  // Tag FIFO: one entry per outstanding read, consumed by the matching return.
  assign w_tag_new.start = r_first;
  assign w_tag_new.last  = (r_rem == WordsW'(1));
  assign w_tag_new.bytes = w_tag_new.last ? r_last_bytes : 5'd16;
  assign w_tag_new.port  = r_port;
  assign w_tag_new.words = r_words;
  assign w_tag_head      = r_tag_mem[r_tag_rd];
  assign w_tag_pop       = io_bus.ram_rd_valid && (r_tag_count != '0);

  always_ff @(posedge i_clk_ram_ctl) begin
    if (w_rd_en) r_tag_mem[r_tag_wr] <= w_tag_new;
  end

  always_ff @(posedge i_clk_ram_ctl) begin
    if (i_rst) begin
      r_tag_wr    <= '0;
      r_tag_rd    <= '0;
      r_tag_count <= '0;
    end else begin
      if (w_rd_en)   r_tag_wr <= r_tag_wr + PtrW'(1);
      if (w_tag_pop) r_tag_rd <= r_tag_rd + PtrW'(1);
      r_tag_count <= r_tag_count + CntW'(w_rd_en) - CntW'(w_tag_pop);
    end
  end

  assign w_data_new.data  = io_bus.ram_rd_data[127:0];
  assign w_data_new.start = w_tag_head.start;
  assign w_data_new.last  = w_tag_head.last;
  assign w_data_new.bytes = w_tag_head.bytes;
  assign w_data_new.port  = w_tag_head.port;
  assign w_data_head      = r_data_mem[r_data_rd];
  assign w_eg_valid       = (r_data_count != '0);
  assign w_data_pop       = w_eg_valid & io_bus.eg_ready;
  assign w_unused_hi      = ^io_bus.ram_rd_data[143:128];

  always_ff @(posedge i_clk_ram_ctl) begin
    if (w_tag_pop) r_data_mem[r_data_wr] <= w_data_new;
  end

  always_ff @(posedge i_clk_ram_ctl) begin
    if (i_rst) begin
      r_data_wr    <= '0;
      r_data_rd    <= '0;
      r_data_count <= '0;
      r_free_valid <= 1'b0;
      r_free_words <= '0;
      r_err_zero   <= 1'b0;
      r_err_unexp  <= 1'b0;
    end else begin
      if (w_tag_pop)  r_data_wr <= r_data_wr + PtrW'(1);
      if (w_data_pop) r_data_rd <= r_data_rd + PtrW'(1);
      r_data_count <= r_data_count + CntW'(w_tag_pop) - CntW'(w_data_pop);
      r_free_valid <= w_tag_pop && w_tag_head.last;
      r_free_words <= (w_tag_pop && w_tag_head.last) ? w_tag_head.words : '0;
      if (w_desc_fire && (io_bus.desc_len == '0))          r_err_zero  <= 1'b1;
      if (io_bus.ram_rd_valid && (r_tag_count == '0))       r_err_unexp <= 1'b1;
    end
  end

  assign io_bus.desc_ready        = w_desc_ready;
  assign io_bus.ram_rd_en         = w_rd_en;
  assign io_bus.ram_rd_addr       = r_addr;
  assign io_bus.eg_valid          = w_eg_valid;
  assign io_bus.eg_data           = w_eg_valid ? w_data_head.data  : '0;
  assign io_bus.eg_bytes          = w_eg_valid ? w_data_head.bytes : '0;
  assign io_bus.eg_start          = w_eg_valid & w_data_head.start;
  assign io_bus.eg_last           = w_eg_valid & w_data_head.last;
  assign io_bus.eg_port           = w_eg_valid ? w_data_head.port  : '0;
  assign io_bus.free_valid        = r_free_valid;
  assign io_bus.free_words        = r_free_words;
  assign io_bus.err_zero_len      = r_err_zero;
  assign io_bus.err_unexpected_rd = r_err_unexp;
endmodule

// File: tb/tb_egress_frame_reader.sv
// Directed and randomized bench for egress_frame_reader with a behavioural RAM and a
// frame-level reference model of the expected reads, beats and credit returns.
module tb_egress_frame_reader;
  localparam int unsigned ADDR_BITS  = 18;
  localparam int unsigned LEN_BITS   = 14;
  localparam int unsigned PORT_BITS  = 4;
  localparam int unsigned FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  egress_frame_reader_if #(.ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .PORT_BITS(PORT_BITS)) bus ();

  egress_frame_reader #(
    .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .PORT_BITS(PORT_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk_ram_ctl(clk),
    .i_rst        (rst),
    .io_bus       (bus)
  );

  typedef struct { logic [138:0] v; int cyc; } beat_t;
  typedef struct { int addr; int cyc; } rd_t;
  typedef struct { int words; int cyc; } fr_t;
  typedef struct { int addr; int due; } pend_t;
  typedef struct { int addr; int len; int port; } desc_t;

  beat_t beat_q[$];
  rd_t   rd_q[$];
  fr_t   free_q[$];
  pend_t ram_q[$];
  int    acc_q[$];
  int    ret_q[$];

  int cyc = 0;
  int ram_lat = 8;
  bit ram_rand_lat = 1'b0;
  int ready_mode = 0;
  int outstanding = 0;
  int max_out = 0;
  int stable_viol = 0;
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [127:0] ram_word(input int a);
    logic [31:0] x;
    x = 32'(a);
    return {x ^ 32'hA5C3_0000, x * 32'h9E37_79B1, ~x, x + 32'h1234_5678};
  endfunction

  function automatic int n_words(input int len);
    return (len + 15) / 16;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus in-order RAM with configurable latency; all sampling on the falling edge.
  initial begin
    logic [138:0] prev_v, cur_v;
    bit prev_stall;
    rd_t r; beat_t b; fr_t f; pend_t p;
    prev_stall = 1'b0;
    prev_v = '0;
    bus.ram_rd_valid = 1'b0;
    bus.ram_rd_data  = '0;
    forever begin
      @(negedge clk);
      cur_v = {bus.eg_data, bus.eg_bytes, bus.eg_start, bus.eg_last, bus.eg_port};
      if (rst) begin
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        if (bus.desc_valid && bus.desc_ready) acc_q.push_back(cyc);
        if (bus.ram_rd_en) begin
          r.addr = int'(bus.ram_rd_addr); r.cyc = cyc;
          rd_q.push_back(r);
          p.addr = r.addr;
          p.due  = cyc + (ram_rand_lat ? int'($urandom_range(1, 12)) : ram_lat);
          ram_q.push_back(p);
          outstanding++;
        end
        if (bus.eg_valid && bus.eg_ready) begin
          b.v = cur_v; b.cyc = cyc;
          beat_q.push_back(b);
          outstanding--;
        end
        if (bus.free_valid) begin
          f.words = int'(bus.free_words); f.cyc = cyc;
          free_q.push_back(f);
        end
        if (outstanding > max_out) max_out = outstanding;
        if (prev_stall && (bus.eg_valid !== 1'b1 || cur_v !== prev_v)) stable_viol++;
        prev_stall = bus.eg_valid && !bus.eg_ready;
        prev_v     = cur_v;
      end
      if (ram_q.size() > 0 && ram_q[0].due <= cyc) begin
        p = ram_q.pop_front();
        bus.ram_rd_valid = 1'b1;
        bus.ram_rd_data  = {16'($urandom), ram_word(p.addr)};
        ret_q.push_back(cyc);
      end else begin
        bus.ram_rd_valid = 1'b0;
        bus.ram_rd_data  = '0;
      end
    end
  end

  initial begin
    bus.eg_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.eg_ready = 1'b1;
        1:       bus.eg_ready = 1'b0;
        default: bus.eg_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic clear_logs();
    beat_q.delete(); rd_q.delete(); free_q.delete(); acc_q.delete(); ret_q.delete();
    max_out = 0;
  endtask

  task automatic send(input int a, input int l, input int p);
    int t;
    t = 0;
    bus.desc_valid = 1'b1;
    bus.desc_addr  = ADDR_BITS'(a);
    bus.desc_len   = LEN_BITS'(l);
    bus.desc_port  = PORT_BITS'(p);
    while (!bus.desc_ready && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) chk("desc_accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int t;
    t = 0;
    while (beat_q.size() < n && t < 5000) begin @(posedge clk); #1; t++; end
    chk({tag, " beats_timeout"}, t < 5000, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference: every frame is words=ceil(len/16) reads from consecutive (wrapping) addresses,
  // one beat per word with full 16-byte beats except the remainder, one credit return per frame.
  task automatic expect_frames(input string tag, input desc_t d[$]);
    int ri, bi, w, a, by;
    logic [138:0] exp_v, got_v;
    ri = 0; bi = 0;
    foreach (d[k]) begin
      w = n_words(d[k].len);
      for (int i = 0; i < w; i++) begin
        a  = (d[k].addr + i) % (1 << ADDR_BITS);
        by = (i == w - 1) ? d[k].len - 16 * i : 16;
        chk($sformatf("%s rd_addr f%0d w%0d", tag, k, i), (ri < rd_q.size()) ? rd_q[ri].addr : -1, a);
        exp_v = {ram_word(a), 5'(by), i == 0, i == w - 1, 4'(d[k].port)};
        got_v = (bi < beat_q.size()) ? beat_q[bi].v : '1;
        chk($sformatf("%s beat f%0d w%0d", tag, k, i), got_v, exp_v);
        ri++; bi++;
      end
      chk($sformatf("%s free_words f%0d", tag, k), (k < free_q.size()) ? free_q[k].words : -1, w);
    end
    chk({tag, " n_reads"}, rd_q.size(), ri);
    chk({tag, " n_beats"}, beat_q.size(), bi);
    chk({tag, " n_frees"}, free_q.size(), d.size());
  endtask

  initial begin
    desc_t dl[$];
    desc_t dd;
    int t, tot;
    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_len   = '0;
    bus.desc_port  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst desc_ready", bus.desc_ready, 0);
    chk("rst rd_en", bus.ram_rd_en, 0);
    chk("rst rd_addr", bus.ram_rd_addr, 0);
    chk("rst eg", {bus.eg_valid, bus.eg_data, bus.eg_bytes, bus.eg_start, bus.eg_last, bus.eg_port}, 0);
    chk("rst free", {bus.free_valid, bus.free_words}, 0);
    chk("rst errs", {bus.err_zero_len, bus.err_unexpected_rd}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst desc_ready", bus.desc_ready, 1);

    // Basic 4-word frame with fixed latency 8: timing of reads, beats and credit.
    clear_logs();
    send(32'h100, 64, 3);
    wait_beats("basic", 4);
    dl.delete(); dd = '{32'h100, 64, 3}; dl.push_back(dd);
    expect_frames("basic", dl);
    chk("basic first_rd_cycle", rd_q[0].cyc, acc_q[0] + 1);
    chk("basic rd_back_to_back", rd_q[3].cyc, rd_q[0].cyc + 3);
    chk("basic beat_latency", beat_q[0].cyc, ret_q[0] + 1);
    chk("basic free_latency", free_q[0].cyc, ret_q[3] + 1);

    // Partial last word and single-word frame.
    clear_logs();
    send(32'h200, 61, 5);
    send(32'h300, 16, 9);
    wait_beats("partial", 5);
    dl.delete();
    dd = '{32'h200, 61, 5}; dl.push_back(dd);
    dd = '{32'h300, 16, 9}; dl.push_back(dd);
    expect_frames("partial", dl);

    // Address wrap at the top of RAM.
    clear_logs();
    send(32'h3FFFF, 32, 2);
    wait_beats("wrap", 2);
    dl.delete(); dd = '{32'h3FFFF, 32, 2}; dl.push_back(dd);
    expect_frames("wrap", dl);

    // Long frame with egress stalled: reads must stop once 16 words are outstanding.
    clear_logs();
    ready_mode = 1;
    send(32'h1000, 1600, 6);
    repeat (200) @(posedge clk);
    #1;
    chk("stall reads_issued", rd_q.size(), FIFO_DEPTH);
    chk("stall max_outstanding", max_out, FIFO_DEPTH);
    chk("stall no_beats", beat_q.size(), 0);
    ready_mode = 0;
    wait_beats("stall", 100);
    dl.delete(); dd = '{32'h1000, 1600, 6}; dl.push_back(dd);
    expect_frames("stall", dl);
    chk("stall max_outstanding_total", max_out <= FIFO_DEPTH, 1);

    // Back-to-back descriptors: one idle cycle between frames.
    clear_logs();
    send(32'h40, 48, 1);
    send(32'h80, 20, 7);
    wait_beats("b2b", 5);
    dl.delete();
    dd = '{32'h40, 48, 1}; dl.push_back(dd);
    dd = '{32'h80, 20, 7}; dl.push_back(dd);
    expect_frames("b2b", dl);
    chk("b2b second_accept", acc_q[1], rd_q[2].cyc + 1);
    chk("b2b second_first_rd", rd_q[3].cyc, acc_q[1] + 1);

    // Random frames with random latency and random egress back-pressure.
    clear_logs();
    ready_mode = 2;
    ram_rand_lat = 1'b1;
    dl.delete();
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      dd.addr = int'($urandom_range(0, (1 << ADDR_BITS) - 1));
      dd.len  = int'($urandom_range(1, 300));
      dd.port = int'($urandom_range(0, 15));
      dl.push_back(dd);
      tot += n_words(dd.len);
      send(dd.addr, dd.len, dd.port);
    end
    wait_beats("rand", tot);
    expect_frames("rand", dl);
    chk("rand max_outstanding", max_out <= FIFO_DEPTH, 1);
    ready_mode = 0;
    ram_rand_lat = 1'b0;

    // Zero-length descriptor.
    clear_logs();
    send(32'h55, 0, 4);
    repeat (5) @(posedge clk);
    #1;
    chk("zero err_zero_len", bus.err_zero_len, 1);
    chk("zero no_reads", rd_q.size(), 0);
    chk("zero no_free", free_q.size(), 0);
    chk("zero desc_ready", bus.desc_ready, 1);

    // Reset mid-frame: returns still in flight arrive after reset.
    clear_logs();
    send(32'h500, 160, 8);
    t = 0;
    while (rd_q.size() < 5 && t < 200) begin @(posedge clk); #1; t++; end
    chk("midrst reads_started", rd_q.size() >= 5, 1);
    rst = 1'b1;
    #1;
    chk("midrst desc_ready_in_rst", bus.desc_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst eg_cleared", {bus.eg_valid, bus.eg_data, bus.eg_bytes, bus.eg_port}, 0);
    chk("midrst errs_cleared", {bus.err_zero_len, bus.err_unexpected_rd}, 0);
    chk("midrst rd_addr", {bus.ram_rd_en, bus.ram_rd_addr}, 0);
    chk("midrst desc_ready", bus.desc_ready, 1);
    t = 0;
    while (ram_q.size() > 0 && t < 100) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("midrst err_unexpected_rd", bus.err_unexpected_rd, 1);
    chk("midrst no_beats", beat_q.size(), 0);
    chk("midrst no_free", free_q.size(), 0);
    clear_logs();
    send(32'h600, 40, 10);
    wait_beats("after_rst", 3);
    dl.delete(); dd = '{32'h600, 40, 10}; dl.push_back(dd);
    expect_frames("after_rst", dl);
    chk("after_rst err_sticky", bus.err_unexpected_rd, 1);

    chk("egress_stable_under_stall", stable_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
